icu_refill_responder: RTL
=========================

# icu_refill_responder

Responder for the ICU refill interface (`icu_biu_*`/`biu_icu_*`): accepts line or single-beat refill requests from the instruction cache unit and returns 64-bit beats read directly from a synchronous single-read-port SRAM. No AXI in the path. Stands in for the BIU in cache-only test tops and serves as a low-latency refill path on boot-ROM/TCM-backed builds. Enforces the same ack / data_valid / data_last / fault contract the ICU expects.

## Interface
- `LINE_BEATS`, 4: beats per cache line (32 B line, 8 B beat); power of two.
- `MEM_AW`, 16: address bits decoded by the SRAM; byte address width.
- `MEM_BASE`, 32'h0000_0000: SRAM base; only bits [31:MEM_AW] are compared.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `icu_biu_req` in 1: refill request, level, held until ack.
- `icu_biu_addr` in 29 [31:3]: beat-aligned request address.
- `icu_biu_single` in 1: 1 = single beat, 0 = full line.
- `biu_icu_ack` out 1: one-cycle request acceptance pulse.
- `biu_icu_data_valid` out 1: beat valid.
- `biu_icu_data_last` out 1: final beat of a transaction.
- `biu_icu_data` out 64: beat data.
- `biu_icu_fault` out 1: access fault, only with valid and last.
- `ext_stall` in 1: suppress SRAM read issue this cycle.
- `ram_ren` out 1: SRAM read enable.
- `ram_raddr` out 32: SRAM byte read address, bits [2:0] = 0.
- `ram_rdata` in 64: SRAM read data, valid the cycle after `ram_ren`.

## Operation
- States: IDLE, ACK, READ, DRAIN, FAULT.
- IDLE: on `icu_biu_req` = 1 at a clock edge, capture addr, single, and the range check; go to ACK.
- ACK: `biu_icu_ack` = 1 for exactly this cycle. Next state is FAULT if `addr[31:MEM_AW] != MEM_BASE[31:MEM_AW]`, else READ. `icu_biu_req` is ignored in every state except IDLE.
- READ: each cycle with `ext_stall` = 0:
  - `ram_ren` = 1 and `ram_raddr` = beat address.
  - Beat counter increments.
  - After the final issue (count = `LINE_BEATS`-1, or the first issue if single), go to DRAIN.
  - While `ext_stall` = 1: `ram_ren` = 0 and the counter holds.
- Beat address for beat k of a line: `{addr[31:5], (addr[4:3]+k) mod 4, 3'b000}`. This is critical-word-first with wrap inside the 32 B line. Single: `{addr, 3'b000}`.
- Data return:
  - `biu_icu_data_valid` is `ram_ren` registered.
  - `biu_icu_data` = `ram_rdata` while valid, 0 otherwise.
  - `biu_icu_data_last` = registered "final issue" flag.
- DRAIN: final beat presents (valid = 1, last = 1); go to IDLE.
- FAULT: valid = 1, last = 1, fault = 1, data = 0 for one cycle; no SRAM access; go to IDLE.
- Reset (any time, including mid-burst): state IDLE, counter 0. All outputs 0: ack, valid, last, fault, data, `ram_ren`, `ram_raddr`. No further beats are produced after reset release.

## Timing
- Cycle 0 = cycle in which req is sampled high.
  - Ack in cycle 1.
  - Reads in cycles 2..5 with no stall.
  - Valid in cycles 3..6.
  - Last in cycle 6.
- Single, no stall: ack cycle 1, read cycle 2, valid + last cycle 3.
- Fault: ack cycle 1, valid + last + fault cycle 2.
- Each stalled READ cycle delays all later beats by one and inserts one valid = 0 gap.
- Back-to-back: after the last beat (DRAIN), IDLE is the next cycle. The earliest next ack is 2 cycles after the last beat (1 cycle after FAULT + 1).
- Exactly `LINE_BEATS` (line) or 1 (single) valid beats per ack; last is never asserted without valid.

## Test plan
- Line refill, addr[31:3] = 0x0000_1002 (byte 0x8010), data preloaded = byte address:
  - Ack at cycle 1.
  - Beats 0x8010, 0x8018, 0x8000, 0x8008 in cycles 3–6.
  - Last only in cycle 6; fault = 0.
- Single, byte 0x0040 -> one beat, data 0x40, valid + last in cycle 3; `ram_ren` high only in cycle 2.
- Out-of-range, byte 0x0001_0000 with MEM_AW = 16 -> ack cycle 1; cycle 2 valid = last = fault = 1, data 0; `ram_ren` never asserted.
- `ext_stall` high in cycles 3–4 during a line from byte 0x0000:
  - Reads at cycles 2, 5, 6, 7.
  - Valid at cycles 3, 6, 7, 8 with data 0x00, 0x08, 0x10, 0x18; last at cycle 8.
- `resetn` low in cycle 4 of a line, req held high through reset -> all outputs 0 asynchronously; after release, a fresh ack and 4 beats from the start beat, with no leftover beats.
- Req re-held in the cycle after ack, during READ -> no second ack until IDLE. The second transaction's ack comes 2 cycles after the first's last beat.

Source files
------------

// File: rtl/icu_refill_responder.sv
// ICU refill responder: serves line (critical-word-first, wrapping) or single-beat refills from a 1-cycle SRAM.
// Ack 1 cycle after req; first beat 2 cycles after ack; ext_stall holds read issue and opens a valid gap per stalled cycle.
module icu_refill_responder #(
    parameter int          LINE_BEATS = 4,
    parameter int          MEM_AW     = 16,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        icu_biu_req,
    input  logic [31:3] icu_biu_addr,
    input  logic        icu_biu_single,
    output logic        biu_icu_ack,
    output logic        biu_icu_data_valid,
    output logic        biu_icu_data_last,
    output logic [63:0] biu_icu_data,
    output logic        biu_icu_fault,
    input  logic        ext_stall,
    output logic        ram_ren,
    output logic [31:0] ram_raddr,
    input  logic [63:0] ram_rdata
);

    localparam int              OB       = $clog2(LINE_BEATS);
    localparam logic [OB-1:0]   LAST_CNT = OB'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_READ,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:3]     r_addr;
    logic            r_single;
    logic            r_oor;
    logic [OB-1:0]   r_cnt;
    logic            r_valid;
    logic            r_last;
    logic            w_ren;
    logic            w_final;
    logic            w_ack;
    logic [OB-1:0]   w_idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_single <= 1'b0;
            r_oor    <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_ren;
            r_last  <= w_ren & w_final;
            if (r_state == S_IDLE && icu_biu_req) begin
                r_addr   <= icu_biu_addr;
                r_single <= icu_biu_single;
                r_oor    <= (icu_biu_addr[31:MEM_AW] != MEM_BASE[31:MEM_AW]);
            end
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (w_ren) begin
                r_cnt <= w_final ? '0 : r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ack   = 1'b0;
        w_ren   = 1'b0;
        w_final = r_single || (r_cnt == LAST_CNT);
        case (r_state)
            S_IDLE:  if (icu_biu_req) w_next = S_ACK;
            S_ACK: begin
                w_ack  = 1'b1;
                w_next = r_oor ? S_FAULT : S_READ;
            end
            S_READ: begin
                if (!ext_stall) begin
                    w_ren = 1'b1;
                    if (w_final) w_next = S_DRAIN;
                end
            end
            S_DRAIN: w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Beat index wraps inside the line so the requested word comes back first.
    assign w_idx = r_addr[OB+2:3] + r_cnt;

    assign ram_ren   = w_ren;
    assign ram_raddr = !w_ren   ? 32'h0 :
                       r_single ? {r_addr, 3'b000} :
                                  {r_addr[31:OB+3], w_idx, 3'b000};

    assign biu_icu_ack        = w_ack;
    assign biu_icu_fault      = (r_state == S_FAULT);
    assign biu_icu_data_valid = r_valid | biu_icu_fault;
    assign biu_icu_data_last  = r_last | biu_icu_fault;
    assign biu_icu_data       = r_valid ? ram_rdata : 64'h0;

endmodule
